fifo_read_arbiter: RTL and testbench
====================================

// Module: fifo_read_arbiter
// PURPOSE
//  Round-robin read scheduler sharing one downstream consumer between N FIFOs.
//  Issues at most one rd_en per cycle, never to an empty FIFO (no underflow by construction).
//  Grants bursts of up to MAX_BURST reads per FIFO to amortise switching.
//  Sits between the FIFO bank's empty flags/read strobes and the read-data mux/consumer.
// PARAMETERS
//  N          4  number of requesting FIFOs (>=2)
//  MAX_BURST  4  max consecutive reads per grant (>=1)
//  IDXW       $clog2(N)  localparam, grant index width
// PORTS
//  clk        in   1     clock, all logic on posedge
//  rst        in   1     synchronous, active-high reset
//  empty      in   N     per-FIFO empty flag, 1 = empty
//  out_ready  in   1     consumer can accept a word this cycle
//  rd_en      out  N     per-FIFO read strobe, one-hot or zero
//  grant_idx  out  IDXW  index of FIFO currently granted (read-data mux select)
//  rd_valid   out  1     read data valid (rd_en delayed 1 cycle, FIFO read latency 1)
//  busy       out  1     1 while in BURST state
// BEHAVIOUR
//  Reset values: state=IDLE, rd_en=0, rd_valid=0, busy=0, grant_idx=0,
//   last_grant=N-1 (so FIFO 0 wins first), burst_cnt=0.
//  rd_en is combinational: rd_en[i] = (state==BURST) && grant_idx==i && !empty[i] && out_ready && !rst.
//   Invariant every cycle: rd_en[i] -> !empty[i]; $onehot0(rd_en).
//  FSM:
//   IDLE : if |(~empty): grant_idx <= first non-empty index after last_grant (wrapping),
//          burst_cnt <= 0, -> BURST. Else stay. No reads in IDLE.
//   BURST: on read (rd_en!=0): burst_cnt++. Exit to IDLE, last_grant <= grant_idx, when
//          (read && burst_cnt==MAX_BURST-1) or empty[grant_idx]==1 (checked before read).
//          out_ready=0: no read, burst_cnt holds, stay in BURST.
//  Latency: first rd_en one cycle after any empty deasserts from IDLE; one IDLE bubble
//   between consecutive bursts.
//  rd_valid <= |rd_en (registered); cleared by rst.
//  Boundaries:
//   - empty[g] rises mid-burst: rd_en drops same cycle, -> IDLE next edge.
//   - Single non-empty FIFO: regranted repeatedly after each bubble (no starvation of self).
//   - Wrap: search from last_grant+1 mod N; last_grant=N-1 searches from 0.
//   - burst_cnt width $clog2(MAX_BURST+1); never exceeds MAX_BURST-1 before exit.
//   - rst mid-burst: rd_en forced 0 in reset cycle; all regs to reset values at edge.
//   - empty and out_ready change same cycle: combinational gating uses current values.
// CONFIGURATION
//  `FIFO_ARB_CHECK_EN defined: embeds SVA at posedge clk disable iff rst:
//   per-i rd_en[i] |-> !empty[i]; $onehot0(rd_en); rd_en!=0 |-> out_ready;
//   state==BURST && out_ready && !empty[grant_idx] |-> rd_en!=0 (no lost slot).
//   Failures report $error with grant_idx and $time.
//  Undefined: no assertions compiled; RTL function identical.
// STRUCTURE
//  fifo_arb_pkg: typedef enum logic {IDLE, BURST} arb_state_t; shared by RTL and bench.
//  Sub-module fifo_rr_pick (combinational): inputs req[N] (= ~empty), last[IDXW];
//   outputs any, idx[IDXW]; rotate-priority search. Top holds FSM, counters, strobes.
// TESTING (N=4, MAX_BURST=4)
//  1. rst=1 2 cycles, empty=4'b0000 -> rd_en=0, rd_valid=0, busy=0; after release first grant_idx=0.
//  2. empty=4'b1111, out_ready=1 for 20 cycles -> rd_en never !=0, busy=0.
//  3. empty=4'b0000, out_ready=1 -> grants 0,1,2,3,0; 4 rd_en pulses each, 1 bubble between.
//  4. Only FIFO 2 non-empty, empty[2] rises after 2 reads -> rd_en[2] high 2 cycles, then IDLE.
//  5. out_ready=0 for 3 cycles after 1st read of burst -> rd_en=0, then 3 more reads resume.
//  6. rst=1 at 2nd read of burst on FIFO 1 -> rd_en=0 that cycle; next grant is FIFO 0.
//  All runs with FIFO_ARB_CHECK_EN defined: zero assertion failures.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO read arbiter: the two-state scheduler encoding.
package fifo_arb_pkg;

  // IDLE picks the next FIFO to serve; BURST issues reads to the granted FIFO.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fifo_rr_pick.sv
// Rotating-priority picker: returns the first requester after 'last', wrapping
// around, with 'last' itself at the lowest priority.
module fifo_rr_pick #(
  parameter int N = 4,
  localparam int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] last,
  output logic            any,
  output logic [IDXW-1:0] idx
);

  logic [IDXW-1:0] cand;

  // Scan from the farthest offset down to the nearest so the closest requester after 'last' wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IDXW'((int'(last) + k) % N);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin read scheduler that shares one consumer between N FIFOs.
// Grants bursts of up to MAX_BURST reads, never strobes an empty FIFO, and
// leaves one IDLE bubble between bursts.
// Optional macro FIFO_ARB_CHECK_EN embeds protocol assertions; the logic is
// identical with or without it.
module fifo_read_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_BURST = 4,
  localparam int IDXW     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    empty,
  input  logic            out_ready,
  output logic [N-1:0]    rd_en,
  output logic [IDXW-1:0] grant_idx,
  output logic            rd_valid,
  output logic            busy
);

  localparam int CNTW = $clog2(MAX_BURST + 1);
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(MAX_BURST - 1);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(N - 1);

  arb_state_t      state, state_nxt;
  logic [IDXW-1:0] grant_nxt;
  logic [IDXW-1:0] last_grant, last_nxt;
  logic [CNTW-1:0] burst_cnt, cnt_nxt;
  logic            pick_any;
  logic [IDXW-1:0] pick_idx;
  logic            read;

  fifo_rr_pick #(.N(N)) u_pick (
    .req  (~empty),
    .last (last_grant),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Read strobe follows the current empty/ready inputs so a FIFO draining mid-burst is never overread.
  always_comb begin
    rd_en = '0;
    for (int i = 0; i < N; i++) begin
      rd_en[i] = (state == BURST) && (grant_idx == IDXW'(i)) && !empty[i] && out_ready && !rst;
    end
  end

  assign read = |rd_en;
  assign busy = (state == BURST);

  // Next-state logic: pick a winner from IDLE, count reads in BURST, and hand back on drain or burst end.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_idx;
    last_nxt  = last_grant;
    cnt_nxt   = burst_cnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = BURST;
          grant_nxt = pick_idx;
          cnt_nxt   = '0;
        end
      end
      BURST: begin
        if (empty[grant_idx]) begin
          state_nxt = IDLE;
          last_nxt  = grant_idx;
          cnt_nxt   = '0;
        end else if (read) begin
          if (burst_cnt == LAST_BEAT) begin
            state_nxt = IDLE;
            last_nxt  = grant_idx;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = burst_cnt + CNTW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State registers; last_grant resets to N-1 so FIFO 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_idx  <= '0;
      last_grant <= LAST_IDX;
      burst_cnt  <= '0;
      rd_valid   <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant_idx  <= grant_nxt;
      last_grant <= last_nxt;
      burst_cnt  <= cnt_nxt;
      rd_valid   <= read;
    end
  end

`ifdef FIFO_ARB_CHECK_EN
  for (genvar gi = 0; gi < N; gi++) begin : g_chk
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) rd_en[gi] |-> !empty[gi])
      else $error("fifo_read_arbiter: read of empty FIFO, grant_idx=%0d time=%0t", grant_idx, $time);
  end

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(rd_en))
    else $error("fifo_read_arbiter: rd_en not one-hot, grant_idx=%0d time=%0t", grant_idx, $time);

  a_ready: assert property (@(posedge clk) disable iff (rst) (rd_en != '0) |-> out_ready)
    else $error("fifo_read_arbiter: read without out_ready, grant_idx=%0d time=%0t", grant_idx, $time);

  a_no_lost_slot: assert property (@(posedge clk) disable iff (rst)
      (state == BURST && out_ready && !empty[grant_idx]) |-> (rd_en != '0))
    else $error("fifo_read_arbiter: lost read slot, grant_idx=%0d time=%0t", grant_idx, $time);
`else
  // Assertions are compiled only when FIFO_ARB_CHECK_EN is defined.
`endif

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Self-checking bench for fifo_read_arbiter (N=4, MAX_BURST=4). A burst-level
// reference model predicts rd_en, busy, grant_idx and rd_valid every cycle.
module tb_fifo_read_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] empty = 4'b1111;
  logic       out_ready = 1'b0;
  logic [3:0] rd_en;
  logic [1:0] grant_idx;
  logic       rd_valid;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: owner is the FIFO being served (-1 when between bursts).
  int   m_owner = -1;
  int   m_last  = N - 1;
  int   m_reads = 0;
  int   m_grant = 0;
  logic m_valid = 1'b0;

  logic [7:0] exp_v;
  logic [7:0] obs;
  assign obs = {rd_en, busy, grant_idx, rd_valid};

  fifo_read_arbiter #(.N(N), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .empty     (empty),
    .out_ready (out_ready),
    .rd_en     (rd_en),
    .grant_idx (grant_idx),
    .rd_valid  (rd_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, record the model's prediction for this cycle, then advance the model.
  task automatic applyStimulus(input logic [3:0] e, input logic rdy, input logic r);
    logic       read_now;
    logic [3:0] exp_rd;
    logic       found;
    int         c;
    @(negedge clk);
    empty = e;
    out_ready = rdy;
    rst = r;
    #2;
    read_now = !r && (m_owner >= 0) && rdy && !e[m_owner];
    exp_rd = read_now ? (4'b0001 << m_owner) : 4'b0000;
    exp_v = {exp_rd, (m_owner >= 0), 2'(m_grant), m_valid};
    if (r) begin
      m_owner = -1; m_last = N - 1; m_reads = 0; m_grant = 0; m_valid = 1'b0;
    end else begin
      m_valid = read_now;
      if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (!found && !e[c]) begin
            found = 1'b1; m_owner = c; m_grant = c; m_reads = 0;
          end
        end
      end else if (e[m_owner]) begin
        m_last = m_owner; m_owner = -1;
      end else if (read_now) begin
        m_reads++;
        if (m_reads == MB) begin
          m_last = m_owner; m_owner = -1;
        end
      end
    end
  endtask

  task automatic test_reset();
    applyStimulus(4'b0000, 1'b1, 1'b1);
    n_cmp++;
    if (rd_en !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_rd_en: got %b, expected 0000", rd_en);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0000, 1'b1, (i == 0));
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL reset cyc %0d: {rd_en,busy,grant,valid} got %b expected %b", i, obs, exp_v);
      end
    end
    n_cmp++;
    if (grant_idx !== 2'd0 || rd_en !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL reset_first_grant: grant=%0d rd_en=%b, expected grant 0 rd_en 0001", grant_idx, rd_en);
    end
  endtask

  task automatic test_all_empty();
    int strobes = 0;
    applyStimulus(4'b1111, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0);
      if (rd_en != 4'b0000 || busy) strobes++;
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL all_empty cyc %0d: got %b expected %b", i, obs, exp_v);
      end
    end
    n_cmp++;
    if (strobes !== 0) begin
      n_fail++;
      $display("[TB] FAIL all_empty_activity: %0d active cycles, expected 0", strobes);
    end
  endtask

  task automatic test_full_rotation();
    int cnt [4] = '{0, 0, 0, 0};
    applyStimulus(4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 25; i++) begin
      applyStimulus(4'b0000, 1'b1, 1'b0);
      for (int f = 0; f < 4; f++) if (rd_en[f]) cnt[f]++;
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL rotation cyc %0d: got %b expected %b", i, obs, exp_v);
      end
    end
    n_cmp++;
    if (cnt[0] !== 8 || cnt[1] !== 4 || cnt[2] !== 4 || cnt[3] !== 4) begin
      n_fail++;
      $display("[TB] FAIL rotation_counts: got %0d/%0d/%0d/%0d expected 8/4/4/4", cnt[0], cnt[1], cnt[2], cnt[3]);
    end
  endtask

  task automatic test_single_fifo();
    int reads2 = 0;
    logic [3:0] e;
    applyStimulus(4'b1111, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      e = (i < 3) ? 4'b1011 : 4'b1111;
      applyStimulus(e, 1'b1, 1'b0);
      if (rd_en[2]) reads2++;
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL single_fifo cyc %0d: got %b expected %b", i, obs, exp_v);
      end
    end
    n_cmp++;
    if (reads2 !== 2) begin
      n_fail++;
      $display("[TB] FAIL single_fifo_reads: got %0d expected 2", reads2);
    end
  endtask

  task automatic test_backpressure();
    int reads0 = 0;
    logic rdy;
    applyStimulus(4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      rdy = !(i >= 2 && i <= 4);
      applyStimulus(4'b0000, rdy, 1'b0);
      if (rd_en[0]) reads0++;
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL backpressure cyc %0d: got %b expected %b", i, obs, exp_v);
      end
    end
    n_cmp++;
    if (reads0 !== 4) begin
      n_fail++;
      $display("[TB] FAIL backpressure_reads: got %0d expected 4", reads0);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] e;
    applyStimulus(4'b1101, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      e = (i < 3) ? 4'b1101 : 4'b0000;
      applyStimulus(e, 1'b1, (i == 2));
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL reset_mid_burst cyc %0d: got %b expected %b", i, obs, exp_v);
      end
    end
    n_cmp++;
    if (grant_idx !== 2'd0 || rd_en !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_burst_regrant: grant=%0d rd_en=%b expected grant 0 rd_en 0001", grant_idx, rd_en);
    end
  endtask

  task automatic test_random();
    logic [3:0] e;
    logic rdy, r;
    for (int i = 0; i < 2000; i++) begin
      e   = 4'($urandom) & 4'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 63) == 0);
      applyStimulus(e, rdy, r);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL random cyc %0d empty=%b rdy=%b rst=%b: got %b expected %b", i, e, rdy, r, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_empty();
    test_full_rotation();
    test_single_fifo();
    test_backpressure();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
